pwm_count_compare: RTL and testbench
====================================

Name: pwm_count_compare

Overview:
- Downstream consumer of the free-running up-counter's count value.
- Compares the incoming count against a double-buffered duty register and produces a registered PWM waveform, a period-start pulse and a completed-period tally.
- Duty updates take effect only at a period boundary, so no glitched periods occur.
- An enable FSM aligns start-up to count 0 and lets the current period finish cleanly when disabled.

Parameters:
- WIDTH, 4, width of the incoming count; PWM period is 2^WIDTH clk cycles.
- DUTY_RST, 0, reset value of the active and shadow duty registers (WIDTH+1 bits).
- POLARITY, 1, 1 = active-high PWM; 0 = output inverted (inactive level = ~POLARITY).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cnt_in  in  WIDTH  count value from the upstream up-counter (increments by 1 per clk, wraps to 0).
- en  in  1  run request, level.
- duty_wr  in  1  one-cycle write strobe for duty_data.
- duty_data  in  WIDTH+1  requested high-time in clk cycles, 0..2^WIDTH.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-cycle pulse, registered, marks the first cycle of each PWM period.
- period_cnt  out  8  completed-period tally, wraps 255->0.
- duty_pend  out  1  shadow duty written but not yet applied.
- state  out  2  FSM state for debug: IDLE=0, SYNC=1, RUN=2, DRAIN=3.

Behaviour:
- Reset (async) sets:
  - state=IDLE, pwm_out=~POLARITY, period_start=0, period_cnt=0, duty_pend=0.
  - Active duty and shadow duty = DUTY_RST.
  - Reset mid-operation takes effect immediately, with no drain.
- Boundary: the cycle where sampled cnt_in==0.
- Clamp: duty_data > 2^WIDTH is clamped to 2^WIDTH when written to the shadow register.
- Duty write:
  - On duty_wr, shadow <= clamped duty_data and duty_pend <= 1.
  - Back-to-back writes: last write wins.
- Duty apply:
  - Happens at a boundary in SYNC or RUN, and only if duty_pend=1.
  - Active duty <= shadow, duty_pend <= 0.
  - The compare on that same boundary cycle uses the newly applied value.
- Write coinciding with an apply boundary:
  - The boundary applies the previous shadow value.
  - The new value lands in shadow and duty_pend stays/becomes 1.
- Raw compare: raw = (cnt_in < duty_eff), unsigned, WIDTH+1-bit compare. Duty 0 gives always low; duty 2^WIDTH gives always high.
- Latency: pwm_out and period_start at edge t+1 reflect cnt_in sampled at edge t (1 cycle).
- FSM:
  - IDLE:
    - pwm_out = inactive level, period_start = 0.
    - en=1 -> SYNC.
  - SYNC:
    - pwm_out stays inactive.
    - en=0 -> IDLE.
    - At a boundary with en=1 -> RUN; this cycle applies duty, registers pwm_out from the compare, and pulses period_start. period_cnt is not incremented.
  - RUN:
    - Each cycle pwm_out <= raw^~POLARITY.
    - At a boundary with en=1: period_start=1, period_cnt+1, duty apply.
    - en=0 on a non-boundary cycle -> DRAIN; that cycle's pwm_out is computed normally.
    - en=0 on a boundary cycle -> IDLE directly: pwm_out inactive, no period_start, period_cnt+1 (period completed).
  - DRAIN:
    - PWM continues with the current active duty; no duty apply.
    - en=1 before the boundary -> RUN with no output gap.
    - At a boundary with en=0 -> IDLE: pwm_out inactive, period_cnt+1, no period_start.
    - duty_pend is retained across DRAIN/IDLE.
- Upstream count discontinuity (e.g. upstream reset): no error detection. Boundary is purely cnt_in==0.

Test Plan:
- Reset mid-RUN (WIDTH=4, duty 8, rst at cnt_in=3) -> next cycle pwm_out=0, period_start=0, period_cnt=0, state=0, duty_pend=0.
- Start-up alignment: duty 4, en=1 at cnt_in=5 -> state=SYNC for 11 cycles. Then pwm_out high exactly 4 cycles per 16 (following cnt_in 0..3), period_start pulses every 16 cycles, period_cnt increments only from the second boundary onward.
- Mid-period update: in RUN at duty 4, write 12 at cnt_in=2 -> duty_pend=1. The current period stays 4 high, the next period is 12 high, and duty_pend clears on the boundary cycle. A write of 9 on the boundary cycle itself -> that period uses the prior pending value; 9 applies next period.
- Extremes: duty 0 -> pwm_out constant 0. Duty 16 -> constant 1 across boundaries. Duty 20 -> clamped, constant 1. POLARITY=0 with duty 4 -> pwm_out low 4 of 16 cycles, idle level 1.
- Disable: en drops at cnt_in=7 (duty 10) -> DRAIN, waveform completes, pwm_out=0 after the boundary, state=IDLE, period_cnt+1. A separate run with en re-raised at cnt_in=12 in DRAIN -> back to RUN, no gap, period_start at the next boundary. en dropping exactly on a boundary -> IDLE the next cycle, no period_start.
- Tally wrap: 256 full periods in RUN -> period_cnt 255->0. duty_pend survives an IDLE round-trip and applies at the first SYNC boundary.

Source files
------------

// File: rtl/pwm_count_compare.sv
// PWM compare stage fed by an external free-running up-counter.
// Double-buffered duty, boundary-aligned start-up and clean drain.
module pwm_count_compare #(
  parameter int WIDTH    = 4,
  parameter int DUTY_RST = 0,
  parameter bit POLARITY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  input  logic             duty_wr,
  input  logic [WIDTH:0]   duty_data,
  output logic             pwm_out,
  output logic             period_start,
  output logic [7:0]       period_cnt,
  output logic             duty_pend,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [WIDTH:0] FULL =
    {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] DRST =
    DUTY_RST[WIDTH:0];
  localparam logic OFF_LVL = ~POLARITY;

  state_t         st_q;
  state_t         st_d;
  logic [WIDTH:0] act_q;
  logic [WIDTH:0] sh_q;
  logic [WIDTH:0] duty_eff;
  logic [WIDTH:0] wr_val;
  logic           pend_q;
  logic           bnd;
  logic           apply;
  logic           raw;
  logic           lvl;
  logic           pwm_d;
  logic           ps_d;
  logic           inc;

  assign bnd    = (cnt_in == '0);
  assign wr_val = (duty_data > FULL) ? FULL
                                     : duty_data;

  // Boundary apply only when the period will run;
  // the compare this cycle already sees the new duty.
  assign apply = bnd & en & pend_q &
                 ((st_q == SYNC) | (st_q == RUN));

  assign duty_eff = apply ? sh_q : act_q;
  assign raw      = ({1'b0, cnt_in} < duty_eff);
  assign lvl      = POLARITY ? raw : ~raw;

  always_comb begin
    st_d  = st_q;
    pwm_d = OFF_LVL;
    ps_d  = 1'b0;
    inc   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (en) st_d = SYNC;
      end
      SYNC: begin
        if (!en) begin
          st_d = IDLE;
        end else if (bnd) begin
          st_d  = RUN;
          pwm_d = lvl;
          ps_d  = 1'b1;
        end
      end
      RUN: begin
        pwm_d = lvl;
        if (bnd) begin
          inc = 1'b1;
          if (en) begin
            ps_d = 1'b1;
          end else begin
            st_d  = IDLE;
            pwm_d = OFF_LVL;
          end
        end else if (!en) begin
          st_d = DRAIN;
        end
      end
      DRAIN: begin
        pwm_d = lvl;
        if (bnd) begin
          inc = 1'b1;
          if (en) begin
            st_d = RUN;
            ps_d = 1'b1;
          end else begin
            st_d  = IDLE;
            pwm_d = OFF_LVL;
          end
        end else if (en) begin
          st_d = RUN;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= IDLE;
      pwm_out      <= OFF_LVL;
      period_start <= 1'b0;
      period_cnt   <= '0;
      pend_q       <= 1'b0;
      act_q        <= DRST;
      sh_q         <= DRST;
    end else begin
      st_q         <= st_d;
      pwm_out      <= pwm_d;
      period_start <= ps_d;
      if (inc) period_cnt <= period_cnt + 8'd1;
      if (apply) act_q <= sh_q;
      // A write racing an apply lands in shadow and stays pending.
      if (duty_wr) begin
        sh_q   <= wr_val;
        pend_q <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign duty_pend = pend_q;
  assign state     = st_q;

endmodule

// File: tb/tb_pwm_count_compare.sv
// Randomised and directed bench for pwm_count_compare.
// Checks an active-high and an inverted instance against one model.
module tb_pwm_count_compare;

  localparam int W    = 4;
  localparam int FULL = 1 << W;

  logic         clk;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         en;
  logic         duty_wr;
  logic [W:0]   duty_data;

  logic         pwm_out, period_start, duty_pend;
  logic [7:0]   period_cnt;
  logic [1:0]   state;
  logic         pwm_n, ps_n, pend_n;
  logic [7:0]   pcnt_n;
  logic [1:0]   state_n;
  logic [25:0]  obs;

  int checks = 0;
  int failures = 0;

  int m_state, m_cnt, m_act, m_sh;
  bit m_pwm, m_ps, m_pend;

  pwm_count_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en),
    .duty_wr(duty_wr), .duty_data(duty_data),
    .pwm_out(pwm_out), .period_start(period_start),
    .period_cnt(period_cnt), .duty_pend(duty_pend),
    .state(state)
  );

  pwm_count_compare #(.WIDTH(W), .POLARITY(1'b0)) dut_n (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .en(en),
    .duty_wr(duty_wr), .duty_data(duty_data),
    .pwm_out(pwm_n), .period_start(ps_n),
    .period_cnt(pcnt_n), .duty_pend(pend_n),
    .state(state_n)
  );

  assign obs = {pwm_out, period_start, period_cnt,
                duty_pend, state,
                pwm_n, ps_n, pcnt_n, pend_n, state_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [25:0] expv();
    return {m_pwm, m_ps, 8'(m_cnt), m_pend, 2'(m_state),
            ~m_pwm, m_ps, 8'(m_cnt), m_pend, 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pwm = 0; m_ps = 0; m_cnt = 0;
    m_pend = 0; m_act = 0; m_sh = 0;
  endtask

  // Level-true behaviour: 0=IDLE 1=SYNC 2=RUN 3=DRAIN
  task automatic model_step(input int c, input bit e,
                            input bit w, input int d);
    bit bnd;
    int duty;
    bnd  = (c == 0);
    duty = m_act;
    if (bnd && e && m_pend && (m_state == 1 || m_state == 2)) begin
      m_act = m_sh; duty = m_sh; m_pend = 0;
    end
    if (w) begin
      m_sh = (d > FULL) ? FULL : d;
      m_pend = 1;
    end
    m_ps = 0;
    if (m_state == 0) begin
      m_pwm = 0;
      if (e) m_state = 1;
    end else if (m_state == 1) begin
      m_pwm = 0;
      if (!e) m_state = 0;
      else if (bnd) begin
        m_state = 2; m_pwm = (c < duty); m_ps = 1;
      end
    end else if (bnd) begin
      m_cnt   = (m_cnt + 1) % 256;
      m_state = e ? 2 : 0;
      m_ps    = e;
      m_pwm   = e && (c < duty);
    end else begin
      m_state = e ? 2 : 3;
      m_pwm   = (c < duty);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(int'(cnt_in), en, duty_wr, int'(duty_data));
    #1;
    duty_wr = 1'b0;
    cnt_in  = cnt_in + 1'b1;
  endtask

  task automatic goto_cnt(input logic [W-1:0] v);
    for (int i = 0; i < 16 && cnt_in != v; i++) cycle();
  endtask

  task automatic wr(input int d);
    duty_data = 5'(d);
    duty_wr   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; duty_wr = 0; duty_data = 0; cnt_in = 0;
    model_reset();
    cycle(); cycle();
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs, expv());
    end
    checks++;
    if (pwm_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_inv got=%b exp=1", pwm_n);
    end
    rst = 0;
  endtask

  task automatic test_startup();
    int nsync, highs, lows_n, pulses;
    nsync = 0; highs = 0; lows_n = 0; pulses = 0;
    wr(4); cycle();
    goto_cnt(5);
    en = 1;
    for (int i = 0; i < 11; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL startup_sync got=%h exp=%h", obs, expv());
      end
      if (state == 2'd1) nsync++;
    end
    checks++;
    if (nsync != 11) begin
      failures++;
      $display("FAIL sync_len got=%0d exp=11", nsync);
    end
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL startup_run got=%h exp=%h", obs, expv());
      end
      highs  += int'(pwm_out);
      lows_n += int'(!pwm_n);
      pulses += int'(period_start);
    end
    checks++;
    if (highs != 12 || lows_n != 12 || pulses != 3) begin
      failures++;
      $display("FAIL startup_wave got=%0d/%0d/%0d exp=12/12/3",
               highs, lows_n, pulses);
    end
    checks++;
    if (period_cnt !== 8'd2) begin
      failures++;
      $display("FAIL startup_pcnt got=%0d exp=2", period_cnt);
    end
  endtask

  task automatic test_midupdate();
    int highs;
    int exp_hi[3] = '{12, 5, 9};
    bit exp_pd[3] = '{0, 1, 0};
    goto_cnt(2);
    wr(12); cycle();
    checks++;
    if (duty_pend !== 1'b1) begin
      failures++;
      $display("FAIL pend_set got=%b exp=1", duty_pend);
    end
    highs = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      highs += int'(pwm_out);
    end
    checks++;
    if (highs != 1) begin
      failures++;
      $display("FAIL cur_period got=%0d exp=1", highs);
    end
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        goto_cnt(2); wr(5); cycle(); goto_cnt(0);
        wr(9);
      end
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        cycle();
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL midupd got=%h exp=%h", obs, expv());
        end
        if (i == 0) begin
          checks++;
          if (duty_pend !== exp_pd[p]) begin
            failures++;
            $display("FAIL pend_bnd%0d got=%b exp=%b",
                     p, duty_pend, exp_pd[p]);
          end
        end
        highs += int'(pwm_out);
      end
      checks++;
      if (highs != exp_hi[p]) begin
        failures++;
        $display("FAIL upd_period%0d got=%0d exp=%0d",
                 p, highs, exp_hi[p]);
      end
    end
  endtask

  task automatic test_extremes();
    int dv[3] = '{0, 16, 20};
    int eh[3] = '{0, 32, 32};
    int highs;
    for (int k = 0; k < 3; k++) begin
      goto_cnt(3); wr(dv[k]); cycle(); goto_cnt(0);
      highs = 0;
      for (int i = 0; i < 32; i++) begin
        cycle();
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL extreme got=%h exp=%h", obs, expv());
        end
        highs += int'(pwm_out);
      end
      checks++;
      if (highs != eh[k]) begin
        failures++;
        $display("FAIL duty%0d_high got=%0d exp=%0d",
                 dv[k], highs, eh[k]);
      end
    end
  endtask

  task automatic test_disable();
    int highs;
    logic [7:0] pc;
    goto_cnt(3); wr(10); cycle(); goto_cnt(0);
    goto_cnt(7);
    en = 0; highs = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL drain got=%h exp=%h", obs, expv());
      end
      if (i == 0) begin
        checks++;
        if (state !== 2'd3) begin
          failures++;
          $display("FAIL drain_state got=%0d exp=3", state);
        end
      end
      highs += int'(pwm_out);
    end
    checks++;
    if (highs != 3) begin
      failures++;
      $display("FAIL drain_high got=%0d exp=3", highs);
    end
    pc = period_cnt;
    cycle();
    checks++;
    if (state !== 2'd0 || pwm_out !== 1'b0 ||
        period_start !== 1'b0 || period_cnt !== pc + 8'd1) begin
      failures++;
      $display("FAIL drain_end got=%0d/%b/%b/%0d exp=0/0/0/%0d",
               state, pwm_out, period_start, period_cnt, pc + 8'd1);
    end
    en = 1; goto_cnt(0); cycle();
    goto_cnt(5); en = 0; cycle();
    goto_cnt(12); en = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL reraise got=%h exp=%h", obs, expv());
      end
      if (i == 0 && state !== 2'd2) begin
        failures++;
        $display("FAIL reraise_state got=%0d exp=2", state);
      end
      if (i == 4 && period_start !== 1'b1) begin
        failures++;
        $display("FAIL reraise_ps got=%b exp=1", period_start);
      end
    end
    checks += 2;
    goto_cnt(0);
    pc = period_cnt;
    en = 0;
    cycle();
    checks++;
    if (state !== 2'd0 || period_start !== 1'b0 ||
        pwm_out !== 1'b0 || period_cnt !== pc + 8'd1) begin
      failures++;
      $display("FAIL bnd_drop got=%0d/%b/%b/%0d exp=0/0/0/%0d",
               state, period_start, pwm_out, period_cnt, pc + 8'd1);
    end
  endtask

  task automatic test_pend_idle();
    int highs;
    wr(6); cycle();
    goto_cnt(0); cycle();
    checks++;
    if (duty_pend !== 1'b1 || state !== 2'd0) begin
      failures++;
      $display("FAIL pend_idle got=%b/%0d exp=1/0", duty_pend, state);
    end
    en = 1; cycle();
    goto_cnt(0);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL pend_sync got=%h exp=%h", obs, expv());
      end
      if (i == 0 && (duty_pend !== 1'b0 || state !== 2'd2)) begin
        failures++;
        $display("FAIL pend_apply got=%b/%0d exp=0/2",
                 duty_pend, state);
      end
      highs += int'(pwm_out);
    end
    checks += 2;
    if (highs != 6) begin
      failures++;
      $display("FAIL pend_duty got=%0d exp=6", highs);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] p0, prev;
    bit wrapped;
    p0 = period_cnt; prev = period_cnt; wrapped = 0;
    for (int i = 0; i < 256 * 16; i++) begin
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL wrap_cyc got=%h exp=%h", obs, expv());
      end
      if (prev == 8'd255 && period_cnt == 8'd0) wrapped = 1;
      prev = period_cnt;
    end
    checks++;
    if (period_cnt !== p0 || !wrapped) begin
      failures++;
      $display("FAIL wrap got=%0d/%b exp=%0d/1",
               period_cnt, wrapped, p0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) wr($urandom_range(0, 31));
      cycle();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random%0d got=%h exp=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_reset_midrun();
    en = 1; wr(8); cycle();
    goto_cnt(0); cycle();
    goto_cnt(0); cycle();
    goto_cnt(3);
    checks++;
    if (obs !== expv() || state !== 2'd2) begin
      failures++;
      $display("FAIL pre_rst got=%h exp=%h", obs, expv());
    end
    #2 rst = 1;
    #1 model_reset();
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL rst_async got=%h exp=%h", obs, expv());
    end
    cycle();
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL rst_hold got=%h exp=%h", obs, expv());
    end
    rst = 0; en = 0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_midupdate();
    test_extremes();
    test_disable();
    test_pend_idle();
    test_wrap();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
